// File: rtl/serial_detect_pkg.sv
// Shared types and width helpers for the serial "10"-detector scheduler.
package serial_detect_pkg;

  typedef enum logic [1:0] {
    IDLE,
    CLR,
    SHIFT,
    REPORT
  } state_t;

  function automatic int unsigned id_width(input int unsigned n_req);
    return (n_req <= 2) ? 1 : $clog2(n_req);
  endfunction

  function automatic int unsigned cnt_width(input int unsigned word_w);
    return $clog2(word_w + 1);
  endfunction

  function automatic int unsigned bit_width(input int unsigned word_w);
    return (word_w <= 2) ? 1 : $clog2(word_w);
  endfunction

endpackage

// File: rtl/serial_detect_scheduler_if.sv
// Requester / response bundle between the requesters and the scheduler.
interface serial_detect_scheduler_if #(
  parameter int unsigned N_REQ  = 4,
  parameter int unsigned WORD_W = 8
);
  localparam int unsigned ID_W  = serial_detect_pkg::id_width(N_REQ);
  localparam int unsigned CNT_W = serial_detect_pkg::cnt_width(WORD_W);

  logic [N_REQ-1:0]        req_valid;
  logic [N_REQ*WORD_W-1:0] req_data;
  logic [N_REQ-1:0]        req_ready;
  logic                    rsp_valid;
  logic [ID_W-1:0]         rsp_id;
  logic [CNT_W-1:0]        rsp_count;

  modport master (
    output req_valid, req_data,
    input  req_ready, rsp_valid, rsp_id, rsp_count
  );

  modport slave (
    input  req_valid, req_data,
    output req_ready, rsp_valid, rsp_id, rsp_count
  );
endinterface

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first requester after last_grant, wrapping.
module rr_arbiter
  import serial_detect_pkg::*;
#(
  parameter int unsigned N_REQ = 4,
  parameter int unsigned ID_W  = id_width(N_REQ)
) (
  input  logic             en,
  input  logic [N_REQ-1:0] req,
  input  logic [ID_W-1:0]  last_grant,
  output logic [N_REQ-1:0] grant,
  output logic [ID_W-1:0]  grant_idx,
  output logic             any_req
);

  logic [ID_W-1:0] cand;

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    any_req   = 1'b0;
    cand      = '0;
    // Scan last_grant+1 .. last_grant+N_REQ so last_grant itself is checked last.
    for (int unsigned k = 1; k <= N_REQ; k++) begin
      cand = ID_W'((32'(last_grant) + k) % N_REQ);
      if (en && !any_req && req[cand]) begin
        any_req   = 1'b1;
        grant_idx = cand;
      end
    end
    if (any_req) grant = N_REQ'(1) << grant_idx;
  end

endmodule

// File: rtl/serial_detect_scheduler.sv
// Time-shares an external Mealy "10" detector between N_REQ requesters.
module serial_detect_scheduler
  import serial_detect_pkg::*;
#(
  parameter int unsigned N_REQ  = 4,
  parameter int unsigned WORD_W = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  serial_detect_scheduler_if.slave  bus,
  output logic                      det_in,
  output logic                      det_rst,
  input  logic                      det_out,
  output logic                      busy
);

  localparam int unsigned ID_W  = id_width(N_REQ);
  localparam int unsigned CNT_W = cnt_width(WORD_W);
  localparam int unsigned BIT_W = bit_width(WORD_W);

  state_t            state, state_nxt;
  logic [WORD_W-1:0] shreg;
  logic [CNT_W-1:0]  cnt, cnt_step, rsp_count_q;
  logic [BIT_W-1:0]  bit_cnt;
  logic [ID_W-1:0]   last_grant, id_q, rsp_id_q, grant_idx;
  logic [N_REQ-1:0]  grant;
  logic              any_req, arb_en, last_bit;
  logic [WORD_W-1:0] words [N_REQ];

  always_comb begin
    for (int unsigned i = 0; i < N_REQ; i++) words[i] = bus.req_data[i*WORD_W +: WORD_W];
  end

  // Gated by rst so req_ready stays low while reset is held.
  assign arb_en = (state == IDLE) && !rst;

  rr_arbiter #(
    .N_REQ(N_REQ),
    .ID_W (ID_W)
  ) u_arb (
    .en        (arb_en),
    .req       (bus.req_valid),
    .last_grant(last_grant),
    .grant     (grant),
    .grant_idx (grant_idx),
    .any_req   (any_req)
  );

  assign last_bit = (bit_cnt == BIT_W'(WORD_W - 1));
  assign cnt_step = cnt + CNT_W'(det_out);

  always_comb begin
    state_nxt = state;
    det_in    = 1'b0;
    case (state)
      IDLE:   if (any_req) state_nxt = CLR;
      CLR:    state_nxt = SHIFT;
      SHIFT: begin
        det_in = shreg[WORD_W-1];
        if (last_bit) state_nxt = REPORT;
      end
      REPORT: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign det_rst       = rst || (state == CLR);
  assign busy          = (state != IDLE);
  assign bus.req_ready = grant;
  assign bus.rsp_valid = (state == REPORT);
  assign bus.rsp_id    = rsp_id_q;
  assign bus.rsp_count = rsp_count_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      last_grant  <= ID_W'(N_REQ - 1);
      shreg       <= '0;
      cnt         <= '0;
      bit_cnt     <= '0;
      id_q        <= '0;
      rsp_id_q    <= '0;
      rsp_count_q <= '0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: begin
          if (any_req) begin
            shreg      <= words[grant_idx];
            id_q       <= grant_idx;
            last_grant <= grant_idx;
            cnt        <= '0;
            bit_cnt    <= '0;
          end
        end
        SHIFT: begin
          shreg   <= shreg << 1;
          cnt     <= cnt_step;
          bit_cnt <= last_bit ? '0 : bit_cnt + 1'b1;
          // Result registers load as SHIFT ends so they are valid throughout REPORT.
          if (last_bit) begin
            rsp_count_q <= cnt_step;
            rsp_id_q    <= id_q;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_detect_scheduler.sv
// Bench for serial_detect_scheduler with a behavioural "10" detector and frame-level model.
module tb_serial_detect_scheduler;
  localparam int unsigned N = 4;
  localparam int unsigned W = 8;

  logic clk = 1'b0;
  logic rst;
  logic det_in, det_rst, det_out, busy;
  logic saw1 = 1'b0;

  serial_detect_scheduler_if #(.N_REQ(N), .WORD_W(W)) bus ();

  serial_detect_scheduler #(.N_REQ(N), .WORD_W(W)) dut (
    .clk    (clk),
    .rst    (rst),
    .bus    (bus),
    .det_in (det_in),
    .det_rst(det_rst),
    .det_out(det_out),
    .busy   (busy)
  );

  always #5 clk = ~clk;

  // External detector
  assign det_out = saw1 && !det_in;
  always @(posedge clk) saw1 <= det_rst ? 1'b0 : det_in;

  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  function automatic int count_10(input logic [W-1:0] w);
    int c = 0;
    for (int k = W - 1; k >= 1; k--) if (w[k] && !w[k-1]) c++;
    return c;
  endfunction

  function automatic int rr_pick(input logic [N-1:0] v, input int last);
    for (int k = 1; k <= N; k++) begin
      int c = (last + k) % N;
      if (v[c]) return c;
    end
    return -1;
  endfunction

  // Frame model: phase = cycles since acceptance (0 = idle)
  int m_phase = 0, m_last = N - 1, m_id = 0, m_rsp_id = 0, m_rsp_cnt = 0;
  logic [W-1:0] m_word = '0;

  always @(posedge clk) begin : model
    int w;
    if (rst) begin
      m_phase = 0; m_last = N - 1; m_rsp_id = 0; m_rsp_cnt = 0;
    end else if (m_phase == 0) begin
      w = rr_pick(bus.req_valid, m_last);
      if (w >= 0) begin
        m_phase = 1; m_id = w; m_last = w;
        m_word = bus.req_data[w*W +: W];
      end
    end else if (m_phase == W + 2) begin
      m_phase = 0;
    end else begin
      m_phase++;
      if (m_phase == W + 2) begin
        m_rsp_id = m_id;
        m_rsp_cnt = count_10(m_word);
      end
    end
  end

  logic chk_en = 1'b0;
  always @(negedge clk) begin
    int w;
    logic [N-1:0] er;
    logic ed;
    if (chk_en) begin
      er = '0;
      if (!rst && m_phase == 0) begin
        w = rr_pick(bus.req_valid, m_last);
        if (w >= 0) er[w] = 1'b1;
      end
      ed = (m_phase >= 2 && m_phase <= W + 1) ? m_word[W+1-m_phase] : 1'b0;
      check("req_ready", bus.req_ready, er);
      check("busy", busy, m_phase != 0);
      check("det_in", det_in, ed);
      check("det_rst", det_rst, rst || m_phase == 1);
      check("rsp_valid", bus.rsp_valid, m_phase == W + 2);
      check("rsp_id", bus.rsp_id, m_rsp_id);
      check("rsp_count", bus.rsp_count, m_rsp_cnt);
    end
  end

  int t_acc = 0;

  task automatic drive_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_accept(output int idx);
    bit got = 1'b0;
    idx = -1;
    for (int k = 0; k < 40 && !got; k++) begin
      @(negedge clk);
      if (|bus.req_ready) begin
        got = 1'b1;
        for (int i = N - 1; i >= 0; i--) if (bus.req_ready[i]) idx = i;
      end
    end
    check("accept_seen", got, 1);
    t_acc = cyc;
  endtask

  task automatic wait_rsp(input int id, input int cnt);
    bit got = 1'b0;
    for (int k = 0; k < 30 && !got; k++) begin
      @(negedge clk);
      if (bus.rsp_valid === 1'b1) got = 1'b1;
    end
    check("rsp_seen", got, 1);
    check("rsp_latency", cyc - t_acc, W + 2);
    check("lit_rsp_id", bus.rsp_id, id);
    check("lit_rsp_count", bus.rsp_count, cnt);
  endtask

  task automatic run_single(input int id, input logic [W-1:0] w, input int cnt);
    int a;
    drive_edge();
    bus.req_data[id*W +: W] = w;
    bus.req_valid[id] = 1'b1;
    wait_accept(a);
    check("grant_idx", a, id);
    drive_edge();
    bus.req_valid[id] = 1'b0;
    wait_rsp(id, cnt);
  endtask

  initial begin
    int a, ta, npulse;
    logic [W-1:0] rrw [N];
    int exp_order [5];
    rrw = '{8'h3C, 8'h96, 8'h0F, 8'hA5};
    exp_order = '{0, 1, 2, 3, 0};

    rst = 1'b1;
    bus.req_valid = '0;
    bus.req_data = '0;
    @(posedge clk);
    #1;
    chk_en = 1'b1;
    @(negedge clk);
    check("reset_ready", bus.req_ready, 0);
    check("reset_busy", busy, 0);
    check("reset_rsp_valid", bus.rsp_valid, 0);
    check("reset_det_in", det_in, 0);
    check("reset_det_rst", det_rst, 1);
    drive_edge();
    rst = 1'b0;

    run_single(0, 8'hAA, 4);
    run_single(2, 8'hF0, 1);
    run_single(2, 8'h00, 0);
    run_single(2, 8'hFF, 0);
    run_single(2, 8'h55, 3);

    // Two back-to-back frames ending/starting so "1" then "0" straddle the boundary
    drive_edge();
    bus.req_data[1*W +: W] = 8'h01;
    bus.req_valid[1] = 1'b1;
    wait_accept(a);
    check("iso_grant_a", a, 1);
    ta = t_acc;
    drive_edge();
    wait_rsp(1, 0);
    wait_accept(a);
    check("iso_grant_b", a, 1);
    check("iso_period", t_acc - ta, W + 3);
    drive_edge();
    bus.req_valid[1] = 1'b0;
    wait_rsp(1, 0);

    drive_edge();
    rst = 1'b1;
    drive_edge();
    rst = 1'b0;
    for (int i = 0; i < N; i++) bus.req_data[i*W +: W] = rrw[i];
    bus.req_valid = '1;
    ta = 0;
    for (int n = 0; n < 5; n++) begin
      wait_accept(a);
      check("rr_order", a, exp_order[n]);
      if (n > 0) check("rr_period", t_acc - ta, W + 3);
      ta = t_acc;
      drive_edge();
      if (a >= 0) bus.req_data[a*W +: W] = bus.req_data[a*W +: W] ^ 8'hFF;
      if (n == 4) bus.req_valid = '0;
    end
    wait_rsp(0, 1);

    run_single(1, 8'h12, 2);
    drive_edge();
    bus.req_data[1*W +: W] = 8'h30;
    bus.req_data[3*W +: W] = 8'h81;
    bus.req_valid = 4'b1010;
    wait_accept(a);
    check("prio_first", a, 3);
    drive_edge();
    bus.req_valid[3] = 1'b0;
    wait_rsp(3, 1);
    wait_accept(a);
    check("prio_second", a, 1);
    drive_edge();
    bus.req_valid[1] = 1'b0;
    wait_rsp(1, 1);

    drive_edge();
    bus.req_data[0 +: W] = 8'hAA;
    bus.req_valid[0] = 1'b1;
    wait_accept(a);
    drive_edge();
    bus.req_valid[0] = 1'b0;
    repeat (4) drive_edge();
    rst = 1'b1;
    @(negedge clk);
    check("midrst_det_rst", det_rst, 1);
    check("midrst_no_rsp", bus.rsp_valid, 0);
    drive_edge();
    @(negedge clk);
    check("midrst_busy", busy, 0);
    check("midrst_det_rst2", det_rst, 1);
    check("midrst_det_in", det_in, 0);
    drive_edge();
    rst = 1'b0;
    npulse = 0;
    for (int k = 0; k < 15; k++) begin
      @(negedge clk);
      if (bus.rsp_valid !== 1'b0) npulse++;
    end
    check("abort_no_rsp", npulse, 0);
    run_single(0, 8'hAA, 4);

    repeat (3) drive_edge();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: bench did not complete within time limit");
    $fatal(1);
  end

endmodule

// File: doc/serial_detect_scheduler.md
Name: serial_detect_scheduler

Overview:
- Shares one serial Mealy "10" sequence detector between N_REQ requesters.
- Each requester offers a WORD_W-bit word. The block grants round-robin, clears the detector, and shifts the word MSB-first into the detector's `in`.
- It counts detector `out` pulses over the word and returns the count tagged with the requester id.
- The detector sits outside this block and is driven through the det_* ports.

Parameters:
- N_REQ, 4, number of requesters (2..16)
- WORD_W, 8, bits per word shifted into the detector (1..32)
- (local) ID_W = max(1, clog2(N_REQ)); CNT_W = clog2(WORD_W+1)

Ports:
- clk  in  1  system clock, all logic on posedge
- rst  in  1  synchronous, active-high reset
- req_valid  in  N_REQ  per-requester word offered
- req_data  in  N_REQ*WORD_W  word of requester i at bits [i*WORD_W +: WORD_W]
- req_ready  out  N_REQ  one-hot accept pulse; word i is taken when req_valid[i] && req_ready[i]
- det_in  out  1  serial bit to detector `in`
- det_rst  out  1  synchronous clear to detector `rst`
- det_out  in  1  detector Mealy output; combinational on det_in and detector state
- rsp_valid  out  1  one-cycle result pulse
- rsp_id  out  ID_W  requester index of the result
- rsp_count  out  CNT_W  number of det_out=1 cycles during the word
- busy  out  1  high in any state other than IDLE

Behaviour:
- Detector contract:
  - Overlapping "10" detector: det_out = saw1 && !det_in.
  - saw1 <= det_in each clk; det_rst clears saw1.
- States and transitions:
  - IDLE: if any req_valid, choose the winner by round-robin, then go to CLR. Otherwise stay in IDLE.
  - CLR: 1 cycle, then go to SHIFT.
  - SHIFT: exactly WORD_W cycles, then go to REPORT.
  - REPORT: 1 cycle, then go to IDLE.
- Grant (IDLE): the winner is the first i with req_valid[i], searching from last_grant+1 modulo N_REQ.
  - req_ready[winner]=1 combinationally in that same IDLE cycle.
  - On the clock edge: latch the word into shreg, latch the id, update last_grant to the winner, clear cnt.
  - req_ready is 0 in all other states.
- CLR: det_rst=1, det_in=0.
- SHIFT:
  - det_in = shreg[WORD_W-1], then shreg shifts left one bit.
  - cnt += det_out in the same cycle.
  - The bit counter runs 0..WORD_W-1 and wraps.
- REPORT:
  - rsp_valid=1; rsp_id and rsp_count take the latched id and the final cnt.
  - rsp_id and rsp_count hold their value until the next REPORT.
  - No response backpressure.
- Latency: accept at cycle T, CLR at T+1, SHIFT at T+2..T+WORD_W+1, rsp_valid at T+WORD_W+2.
  - Next accept no earlier than T+WORD_W+3.
  - Throughput is one word per WORD_W+3 cycles.
- cnt never exceeds floor(WORD_W/2), so it cannot overflow CNT_W.
- det_in is 0 whenever the state is not SHIFT.
- det_rst = rst || (state==CLR).
- Reset values: state IDLE, last_grant = N_REQ-1 (requester 0 has first priority). req_ready, rsp_valid, rsp_id, rsp_count, busy, det_in, shreg and cnt are all 0.
- Reset mid-operation: the word in flight is aborted silently, with no rsp_valid. The detector is cleared because det_rst follows rst.
- Requester behaviour:
  - A requester may drop req_valid before it is granted; it is then not served.
  - After acceptance, req_data changes have no effect, because the word is latched.
- Simultaneous requests: only one grant per IDLE cycle. Losers keep req_valid high and wait.
- Starvation bound: with all requesters valid, a requester waits at most N_REQ-1 frames.

Decomposition:
- Package serial_detect_pkg holds:
  - the state enum (IDLE, CLR, SHIFT, REPORT);
  - a function computing ID_W and CNT_W from the parameters.
- Sub-module rr_arbiter:
  - inputs: req vector, last_grant, and an enable (state==IDLE);
  - outputs: one-hot grant, binary index, any_req;
  - purely combinational.
  - The last_grant register stays in the top level.

Test Plan:
All tests use N_REQ=4, WORD_W=8, with a behavioural detector model on the bench.
- Reset then single request: req0 data 8'hAA (bits 1,0,1,0,1,0,1,0) -> req_ready[0] at T, rsp_valid at T+10, rsp_id=0, rsp_count=4.
- Single-value words:
  - req2 data 8'hF0 -> rsp_count=1.
  - req2 data 8'h00 -> rsp_count=0.
  - req2 data 8'hFF -> rsp_count=0.
  - req2 data 8'h55 -> rsp_count=3.
- Frame isolation: frame A = 8'h01, then frame B = 8'h01 -> both count 0. This confirms CLR removes the saw1 carried across frames.
- Round-robin order:
  - All four valid continuously, each with a distinct word -> grant order 0,1,2,3,0.
  - Responses arrive every 11 cycles with matching rsp_id and count.
- Priority and pointer: only req1 and req3 valid after last_grant=1 -> req3 is served first, then req1.
- Reset during SHIFT: assert rst at T+5 -> no rsp_valid, busy=0, det_rst=1 during reset. A new req0 8'hAA afterwards yields rsp_count=4.
